// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner: FSM states,
// the (row, col) to hex keymap and the active-low column drive patterns.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] COL0_N = 4'b1110;
    localparam logic [3:0] COL1_N = 4'b1101;
    localparam logic [3:0] COL2_N = 4'b1011;
    localparam logic [3:0] COL3_N = 4'b0111;

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        case (col)
            2'd0:    return COL0_N;
            2'd1:    return COL1_N;
            2'd2:    return COL2_N;
            default: return COL3_N;
        endcase
    endfunction

    // Physical legend layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return 4'hE;
            4'hD: return 4'h0;
            4'hE: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        if (!rows_n[0]) return 2'd0;
        if (!rows_n[1]) return 2'd1;
        if (!rows_n[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_in,
    output logic [3:0] rows_s
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Resets to "no row pulled low" so nothing looks pressed out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= rows_in;
            sync_q <= meta_q;
        end
    end

    assign rows_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle key strobe.
// Define KEYPAD_SCANNER_REPEAT_EN to add auto-repeat strobes while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 24000,
    parameter int DEBOUNCE_CYCLES = 2400000,
    parameter int REPEAT_CYCLES   = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("keypad_scanner: SCAN_CYCLES >= 4, DEBOUNCE_CYCLES >= 2, REPEAT_CYCLES >= 2");
    end

    logic [3:0] rows_s;
    logic       row_bit;

    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    keypad_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rows_in (rows),
        .rows_s  (rows_s)
    );

    assign row_bit = rows_s[row_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    // One shared counter: column dwell in SCAN, stable-cycle count in DEBOUNCE/RELEASE
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (rows_s != 4'hF) begin
                        state_d = DEBOUNCE;
                        row_d   = lowest_low_row(rows_s);
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_bit) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    key_code_d  = key_map(row_q, col_q);
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (row_bit) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (!row_bit) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

`ifdef KEYPAD_SCANNER_REPEAT_EN
        // Held at zero outside PRESSED, so every entry to PRESSED restarts the interval
        rep_cnt_d = '0;
        if (state_q == PRESSED && !row_bit) begin
            if (rep_cnt_q == REP_LAST) begin
                key_valid_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        cols      = col_drive(col_q);
        key_valid = key_valid_q;
        key_code  = key_code_q;
        key_held  = (state_q == PRESSED) || (state_q == RELEASE);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: emulates a 4x4 keypad matrix and checks
// strobes, codes and timing against a keymap/event-level reference model.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 16;
    localparam int REP  = 40;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] key_dn;

    int n_checks = 0;
    int n_fail   = 0;
    int bad_cols = 0;
    int bad_rot  = 0;
    int dbl_vld  = 0;

    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] prev_cols;
    logic       prev_valid;
    logic       prev_rst;

    string keymap_s = "123A456B789CE0FD";

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_dn[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [3:0] model_code(input int r, input int c);
        byte ch;
        ch = keymap_s[r*4+c];
        if (ch >= 8'h30 && ch <= 8'h39) return 4'(ch - 8'h30);
        return 4'(ch - 8'h41 + 10);
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (key_valid) got_q.push_back(key_code);
        if (key_valid && prev_valid) dbl_vld++;
        if (!reset && $countones(~cols) != 1) bad_cols++;
        if (!reset && !prev_rst && cols != prev_cols && cols != {prev_cols[2:0], prev_cols[3]})
            bad_rot++;
        prev_valid = key_valid;
        prev_cols  = cols;
        prev_rst   = reset;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sb_compare(input string tag);
        check_eq({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_code"}, int'(got_q[i]), int'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic press_accept(input int r, input int c, input string tag);
        int n;
        key_dn[r*4+c] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!key_valid && n < 80);
        check_eq({tag, "_valid"}, int'(key_valid), 1);
        check_range({tag, "_latency"}, n, DEB + 3, DEB + 2 + 4*SCAN);
        check_eq({tag, "_code"}, int'(key_code), int'(model_code(r, c)));
        check_eq({tag, "_held"}, int'(key_held), 1);
        exp_q.push_back(model_code(r, c));
    endtask

    task automatic release_key(input int r, input int c, input string tag);
        int n;
        key_dn[r*4+c] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (key_held && n < 80);
        check_eq({tag, "_rel_latency"}, n, DEB + 3);
    endtask

    initial begin
        int r, c, hold, n, zeros;
        logic [3:0] code;

        key_dn     = '0;
        reset      = 1'b1;
        prev_cols  = 4'b1110;
        prev_valid = 1'b0;
        prev_rst   = 1'b1;

        // Reset state and free-running rotation
        ticks(3);
        check_eq("rst_cols", int'(cols), int'(4'b1110));
        check_eq("rst_valid", int'(key_valid), 0);
        check_eq("rst_code", int'(key_code), 0);
        check_eq("rst_held", int'(key_held), 0);
        reset = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            check_eq("rot_cols", int'(cols), int'(~(4'b0001 << ((j / SCAN) % 4)) & 4'hF));
        end

        // Clean press of "6"
        press_accept(1, 2, "key6");
        ticks(5);
        release_key(1, 2, "key6");
        check_eq("key6_code_hold", int'(key_code), 6);
        ticks(6);
        sb_compare("key6");

        // Press bounce on "7": never 16 stable cycles
        for (int k = 0; k < 12; k++) begin
            key_dn[8] = 1'b1;
            ticks(5);
            key_dn[8] = 1'b0;
            ticks(1);
        end
        ticks(10);
        check_eq("pbounce_held", int'(key_held), 0);
        sb_compare("pbounce");

        // Release bounce on "D"
        press_accept(3, 3, "keyD");
        ticks(3);
        key_dn[15] = 1'b0;
        ticks(3);
        key_dn[15] = 1'b1;
        zeros = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (!key_held) zeros++;
        end
        check_eq("rbounce_held_drops", zeros, 0);
        release_key(3, 3, "keyD");
        ticks(6);
        sb_compare("rbounce");

        // Two keys in column 0: "1" held, then "4"
        press_accept(0, 0, "key1");
        ticks(2);
        key_dn[4] = 1'b1;
        ticks(10);
        check_eq("two_code_still1", int'(key_code), 1);
        release_key(0, 0, "key1");
        press_accept(1, 0, "key4");
        ticks(3);
        release_key(1, 0, "key4");
        ticks(6);
        sb_compare("twokeys");

        // Randomized single presses
        for (int it = 0; it < 6; it++) begin
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            hold = $urandom_range(2, 20);
            ticks($urandom_range(0, 15));
            press_accept(r, c, "rnd");
            code = model_code(r, c);
            ticks(hold);
            release_key(r, c, "rnd");
            check_eq("rnd_code_stable", int'(key_code), int'(code));
            ticks(6);
            sb_compare("rnd");
        end

        // Auto-repeat on "A" held for 100 cycles
        press_accept(0, 3, "keyA");
        ticks(100);
        release_key(0, 3, "keyA");
        if (REP_EN)
            for (int k = 0; k < (100 + 2) / REP; k++) exp_q.push_back(4'hA);
        ticks(6);
        sb_compare("repeat");

        // Reset while debouncing "5"
        key_dn[5] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (cols != 4'b1101 && n < 40);
        check_eq("mrst_reach_col1", int'(cols), int'(4'b1101));
        ticks(SCAN + 4);
        reset = 1'b1;
        key_dn[5] = 1'b0;
        ticks(2);
        check_eq("mrst_cols", int'(cols), int'(4'b1110));
        check_eq("mrst_valid", int'(key_valid), 0);
        check_eq("mrst_code", int'(key_code), 0);
        check_eq("mrst_held", int'(key_held), 0);
        reset = 1'b0;
        ticks(40);
        check_eq("mrst_held_after", int'(key_held), 0);
        sb_compare("mrst");

        check_eq("cols_onehot_viol", bad_cols, 0);
        check_eq("cols_rotate_viol", bad_rot, 0);
        check_eq("valid_multi_cycle", dbl_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
